// File: rtl/tuner_ctrl_if.sv
// Tuner control bus: tuning requests and scan inputs toward the controller,
// DDS constant, channel index and status back toward the receiver.
interface tuner_ctrl_if #(
    parameter int width_dds = 32,
    parameter int width_mag = 17,
    parameter int ch_w      = 8
);
    logic                 up;
    logic                 down;
    logic                 scan;
    logic [width_mag-1:0] mag;
    logic [width_mag-1:0] threshold;
    logic [width_dds-1:0] K;
    logic [ch_w-1:0]      channel;
    logic                 mute;
    logic                 busy;
    logic                 scan_done;
    logic                 scan_found;

    modport master (
        output up, down, scan, mag, threshold,
        input  K, channel, mute, busy, scan_done, scan_found
    );

    modport slave (
        input  up, down, scan, mag, threshold,
        output K, channel, mute, busy, scan_done, scan_found
    );
endinterface

// File: rtl/tuner_ctrl.sv
// tuner_ctrl: FM channel tuning / station scan controller.
// Produces the DDS phase constant K incrementally, mutes audio while the
// DDS and CIC settle after a retune, and optionally scans for a station.
// Optional feature macro: TUNER_CTRL_SCAN_EN (scan, averaging, evaluation).
module tuner_ctrl #(
    parameter int                   width_dds = 32,
    parameter int                   width_mag = 17,
    parameter int                   N_CH      = 206,
    parameter logic [width_dds-1:0] K_BASE    = 32'd0,
    parameter logic [width_dds-1:0] K_STEP    = 32'd1,
    parameter int                   SETTLE    = 64,
    parameter int                   AVG       = 16
) (
    input logic         clk,
    input logic         reset,
    tuner_ctrl_if.slave bus
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int AVG_W = $clog2(AVG);
    localparam int ACC_W = width_mag + AVG_W;
    localparam int CNT_W = $clog2((SETTLE > AVG) ? SETTLE : AVG) + 1;
    localparam logic [CH_W-1:0]      CH_LAST = CH_W'(N_CH - 1);
    localparam logic [width_dds-1:0] K_LAST  = K_BASE + width_dds'(N_CH - 1) * K_STEP;

    typedef enum logic [2:0] {S_IDLE, S_STEP, S_SETTLE, S_MEASURE, S_EVAL} state_t;

    state_t               state, state_n;
    logic [CH_W-1:0]      channel;
    logic [width_dds-1:0] k_reg;
    logic [CNT_W-1:0]     cnt;
    logic                 mute_r;
    logic                 go_up, go_dn, clr_cnt, unmute;
    logic                 start_scan, end_scan, found;
    logic                 scanning;
    logic [CH_W-1:0]      ch_next;

    assign ch_next = (channel == CH_LAST) ? '0 : channel + 1'b1;

`ifdef TUNER_CTRL_SCAN_EN
    logic [CH_W-1:0]  start_ch;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mean;
    logic             scan_done_r, scan_found_r;

    assign mean = acc >> AVG_W;

    // Scan bookkeeping: start channel, scan flag, magnitude accumulator, status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_ch     <= '0;
            scanning     <= 1'b0;
            acc          <= '0;
            scan_done_r  <= 1'b0;
            scan_found_r <= 1'b0;
        end else begin
            scan_done_r <= end_scan;
            if (start_scan) begin
                start_ch     <= channel;
                scanning     <= 1'b1;
                scan_found_r <= 1'b0;
            end
            if (end_scan) scanning <= 1'b0;
            if (found) scan_found_r <= 1'b1;
            if (state == S_SETTLE && state_n == S_MEASURE) acc <= '0;
            else if (state == S_MEASURE) acc <= acc + ACC_W'(bus.mag);
        end
    end

    assign bus.scan_done  = scan_done_r;
    assign bus.scan_found = scan_found_r;
`else
    logic unused_scan;
    assign scanning       = 1'b0;
    assign unused_scan    = ^{bus.scan, bus.mag, bus.threshold, start_scan, end_scan, found};
    assign bus.scan_done  = 1'b0;
    assign bus.scan_found = 1'b0;
`endif

    // State register; reset lands in SETTLE so audio stays muted after power-up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_SETTLE;
        else        state <= state_n;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_n    = state;
        go_up      = 1'b0;
        go_dn      = 1'b0;
        clr_cnt    = 1'b0;
        unmute     = 1'b0;
        start_scan = 1'b0;
        end_scan   = 1'b0;
        found      = 1'b0;
        case (state)
            S_IDLE: begin
`ifdef TUNER_CTRL_SCAN_EN
                if (bus.scan) begin
                    start_scan = 1'b1;
                    state_n    = S_STEP;
                end else
`endif
                if (bus.up && !bus.down) begin
                    go_up   = 1'b1;
                    clr_cnt = 1'b1;
                    state_n = S_SETTLE;
                end else if (bus.down && !bus.up) begin
                    go_dn   = 1'b1;
                    clr_cnt = 1'b1;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    clr_cnt = 1'b1;
                    if (scanning) begin
                        state_n = S_MEASURE;
                    end else begin
                        unmute  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
`ifdef TUNER_CTRL_SCAN_EN
            S_STEP: begin
                go_up   = 1'b1;
                clr_cnt = 1'b1;
                state_n = S_SETTLE;
            end
            S_MEASURE: begin
                if (cnt == CNT_W'(AVG - 1)) state_n = S_EVAL;
            end
            S_EVAL: begin
                if (mean >= ACC_W'(bus.threshold)) begin
                    found    = 1'b1;
                    end_scan = 1'b1;
                    unmute   = 1'b1;
                    state_n  = S_IDLE;
                end else if (ch_next == start_ch) begin
                    // Full lap: the step forward lands back on the start channel
                    go_up    = 1'b1;
                    end_scan = 1'b1;
                    clr_cnt  = 1'b1;
                    state_n  = S_SETTLE;
                end else begin
                    state_n = S_STEP;
                end
            end
`endif
            default: ;
        endcase
    end

    // Channel index, incremental K, settle/measure counter and mute flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            channel <= '0;
            k_reg   <= K_BASE;
            cnt     <= '0;
            mute_r  <= 1'b1;
        end else begin
            if (go_up) begin
                if (channel == CH_LAST) begin
                    channel <= '0;
                    k_reg   <= K_BASE;
                end else begin
                    channel <= channel + 1'b1;
                    k_reg   <= k_reg + K_STEP;
                end
            end else if (go_dn) begin
                if (channel == '0) begin
                    channel <= CH_LAST;
                    k_reg   <= K_LAST;
                end else begin
                    channel <= channel - 1'b1;
                    k_reg   <= k_reg - K_STEP;
                end
            end
            if (clr_cnt) cnt <= '0;
            else if (state == S_SETTLE || state == S_MEASURE) cnt <= cnt + 1'b1;
            if (unmute) mute_r <= 1'b0;
            else if (go_up || go_dn || start_scan) mute_r <= 1'b1;
        end
    end

    assign bus.K       = k_reg;
    assign bus.channel = channel;
    assign bus.mute    = mute_r;
    assign bus.busy    = (state != S_IDLE);
endmodule

// File: tb/tb_tuner_ctrl.sv
// Directed bench for tuner_ctrl: N_CH=4, K_BASE=1000, K_STEP=10, SETTLE=4, AVG=4.
// Scan scenarios run only when TUNER_CTRL_SCAN_EN is defined.
module tb_tuner_ctrl;
    localparam int WD = 32;
    localparam int WM = 17;
    localparam int CW = 2;

    typedef struct {
        int ch;
        int k;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mag_mode = 1'b0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total = 0;
    int   exp_ch = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    tuner_ctrl_if #(.width_dds(WD), .width_mag(WM), .ch_w(CW)) bus ();

    tuner_ctrl #(
        .width_dds(WD), .width_mag(WM), .N_CH(4), .K_BASE(32'd1000),
        .K_STEP(32'd10), .SETTLE(4), .AVG(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.mag = mag_mode ? ((bus.channel == 2'd2) ? 17'd200 : 17'd50) : 17'd99;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_ch"}, bus.channel, e.ch);
        chk({tag, "_k"}, bus.K, e.k);
    endtask

    // One manual step from IDLE: dir=1 up, dir=0 down
    task automatic tune(input bit dir, input string tag);
        int n;
        exp_ch = dir ? (exp_ch + 1) % 4 : (exp_ch + 3) % 4;
        sb.push_back('{exp_ch, 1000 + 10 * exp_ch});
        bus.up   = dir;
        bus.down = !dir;
        tick();
        bus.up   = 1'b0;
        bus.down = 1'b0;
        chk({tag, "_busy_t1"}, bus.busy, 1'b1);
        chk({tag, "_mute_t1"}, bus.mute, 1'b1);
        chk({tag, "_ch_t1"}, bus.channel, exp_ch);
        wait_idle(n);
        chk({tag, "_settle_len"}, n, 4);
        chk({tag, "_mute_end"}, bus.mute, 1'b0);
        sb_check(tag);
    endtask

`ifdef TUNER_CTRL_SCAN_EN
    // Run a scan for a fixed window, recording scan_done pulses and mute release
    task automatic run_scan(output int dones, output int done_at, output int unmute_at,
                            output logic mute_at_done);
        dones = 0; done_at = -1; unmute_at = -1; mute_at_done = 1'bx;
        bus.scan = 1'b1;
        tick();
        bus.scan = 1'b0;
        chk("scan_busy", bus.busy, 1'b1);
        chk("scan_mute", bus.mute, 1'b1);
        chk("scan_found_clr", bus.scan_found, 1'b0);
        for (int i = 1; i < 120; i++) begin
            if (bus.scan_done === 1'b1) begin
                dones++;
                if (done_at < 0) begin
                    done_at = i;
                    mute_at_done = bus.mute;
                end
            end
            if (bus.mute === 1'b0 && unmute_at < 0) unmute_at = i;
            tick();
        end
    endtask
`endif

    initial begin
        int n;
        bus.up = 1'b0;
        bus.down = 1'b0;
        bus.scan = 1'b0;
        bus.threshold = 17'd100;

        #12;
        chk("rst_k", bus.K, 1000);
        chk("rst_ch", bus.channel, 0);
        chk("rst_mute", bus.mute, 1'b1);
        chk("rst_busy", bus.busy, 1'b1);
        chk("rst_done", bus.scan_done, 1'b0);
        chk("rst_found", bus.scan_found, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rel_mute_hold", bus.mute, 1'b1);
            tick();
        end
        chk("rel_mute", bus.mute, 1'b0);
        chk("rel_busy", bus.busy, 1'b0);

        tune(1'b1, "up1");
        tune(1'b1, "up2");
        tune(1'b1, "up3");
        tune(1'b1, "up_wrap");
        tune(1'b0, "down_wrap");

        // up and down together: ignored
        bus.up = 1'b1;
        bus.down = 1'b1;
        tick();
        bus.up = 1'b0;
        bus.down = 1'b0;
        chk("both_busy", bus.busy, 1'b0);
        chk("both_ch", bus.channel, exp_ch);

        // second up while busy is dropped
        exp_ch = (exp_ch + 1) % 4;
        sb.push_back('{exp_ch, 1000 + 10 * exp_ch});
        bus.up = 1'b1;
        tick();
        bus.up = 1'b0;
        tick();
        bus.up = 1'b1;
        tick();
        bus.up = 1'b0;
        wait_idle(n);
        sb_check("busy_drop");

        // asynchronous reset in the middle of SETTLE
        tune(1'b1, "pre_rst");
        bus.up = 1'b1;
        tick();
        bus.up = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_ch", bus.channel, 0);
        chk("arst_k", bus.K, 1000);
        chk("arst_mute", bus.mute, 1'b1);
        chk("arst_busy", bus.busy, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_ch = 0;
        wait_idle(n);
        chk("arst_settle_len", n, 4);

`ifdef TUNER_CTRL_SCAN_EN
        begin
            int dones, done_at, unmute_at;
            logic mute_at_done;
            // station on channel 2
            mag_mode = 1'b1;
            sb.push_back('{2, 1020});
            run_scan(dones, done_at, unmute_at, mute_at_done);
            chk("found_dones", dones, 1);
            chk("found_mute_at_done", mute_at_done, 1'b0);
            chk("found_unmute_same", unmute_at, done_at);
            chk("found_flag", bus.scan_found, 1'b1);
            chk("found_busy", bus.busy, 1'b0);
            sb_check("found");
            exp_ch = 2;
            tune(1'b0, "back1");
            tune(1'b0, "back0");
            // nothing above threshold: full lap back to channel 0
            mag_mode = 1'b0;
            sb.push_back('{0, 1000});
            run_scan(dones, done_at, unmute_at, mute_at_done);
            chk("lap_dones", dones, 1);
            chk("lap_mute_at_done", mute_at_done, 1'b1);
            chk("lap_unmute_delay", unmute_at - done_at, 4);
            chk("lap_found", bus.scan_found, 1'b0);
            chk("lap_busy", bus.busy, 1'b0);
            sb_check("lap");
            // reset during MEASURE
            bus.scan = 1'b1;
            tick();
            bus.scan = 1'b0;
            repeat (7) tick();
            #2 reset = 1'b0;
            #1;
            chk("mrst_ch", bus.channel, 0);
            chk("mrst_k", bus.K, 1000);
            chk("mrst_mute", bus.mute, 1'b1);
            chk("mrst_busy", bus.busy, 1'b1);
            chk("mrst_done", bus.scan_done, 1'b0);
            chk("mrst_found", bus.scan_found, 1'b0);
            @(posedge clk);
            #1 reset = 1'b1;
            wait_idle(n);
        end
`else
        // scan is ignored without the scan feature
        bus.scan = 1'b1;
        tick();
        bus.scan = 1'b0;
        chk("noscan_busy", bus.busy, 1'b0);
        chk("noscan_mute", bus.mute, 1'b0);
        chk("noscan_done", bus.scan_done, 1'b0);
        chk("noscan_ch", bus.channel, exp_ch);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/tuner_ctrl.md
# tuner_ctrl

Channel tuning and station-scan controller for the FM receiver. It generates the DDS phase constant `K` for the radio core, either by manual channel up/down steps or by an automatic scan. During a scan it measures averaged CORDIC magnitude on each channel and stops on the first channel above a threshold. It mutes the demodulated audio while the DDS and CIC filters settle after every retune, and it runs in the base-band clock domain.

## Interface
- `width_dds`, 32: width of `K`.
- `width_mag`, 17: width of the magnitude input; matches CORDIC width.
- `N_CH`, 206: number of channels, indexed 0..N_CH-1.
- `K_BASE`, 32'd0: `K` for channel 0.
- `K_STEP`, 32'd1: `K` increment per channel.
- `SETTLE`, 64: number of mute/settle cycles after a retune; ≥1.
- `AVG`, 16: magnitude samples averaged per channel; power of 2, ≥2.

Ports:
- `clk` in 1: base-band clock.
- `reset` in 1: asynchronous, active-low reset.
- `up` in 1: single-cycle request to tune one channel up.
- `down` in 1: single-cycle request to tune one channel down.
- `scan` in 1: single-cycle request to start an upward scan.
- `mag` in width_mag: unsigned CORDIC magnitude, one sample per `clk`.
- `threshold` in width_mag: unsigned scan detection level; must be held static during a scan.
- `K` out width_dds: DDS phase constant; registered.
- `channel` out $clog2(N_CH): current channel index.
- `mute` out 1: high while audio is invalid.
- `busy` out 1: high in any state other than IDLE.
- `scan_done` out 1: one-cycle pulse when a scan ends.
- `scan_found` out 1: level; 1 when the last scan ended on a detected station.

## Operation
- FSM states: IDLE, STEP, SETTLE, MEASURE, EVAL.
- Reset values:
  - `channel`=0, `K`=K_BASE, `mute`=1, `busy`=1, `scan_done`=0, `scan_found`=0.
  - State=SETTLE, with the settle counter at 0.
- IDLE:
  - `up` alone: `channel` increments (N_CH-1 wraps to 0), then go to SETTLE.
  - `down` alone: `channel` decrements (0 wraps to N_CH-1), then go to SETTLE.
  - `up` and `down` in the same cycle: both ignored.
  - `scan`: latch start channel, clear `scan_found`, go to STEP. `scan` takes priority over `up`/`down`.
- `K` is maintained incrementally:
  - It tracks ±K_STEP with each channel step.
  - On wrap it loads K_BASE or K_BASE+(N_CH-1)*K_STEP; the latter is computed at elaboration.
  - `K` always equals K_BASE+channel*K_STEP modulo 2^width_dds.
- STEP (scan only): `channel`+1 with wrap, `K` updated, go to SETTLE.
- SETTLE:
  - Counts SETTLE cycles.
  - Then goes to MEASURE if scanning, otherwise to IDLE with `mute` cleared.
- MEASURE:
  - Clears the accumulator on entry, then accumulates AVG consecutive `mag` samples.
  - Accumulator width is width_mag+$clog2(AVG); no overflow is possible.
- EVAL:
  - The mean is the accumulator right-shifted by $clog2(AVG), truncated.
  - If mean ≥ `threshold`: set `scan_found`=1, pulse `scan_done`, clear `mute`, go to IDLE.
  - Else, if the next channel would equal the start channel (full lap): step back to the start channel, pulse `scan_done`, keep `scan_found`=0, go to SETTLE (non-scan). This unmutes on the start channel.
  - Else go to STEP.
- All `up`/`down`/`scan` requests arriving while `busy`=1 are dropped, not queued.
- Reset assertion in any state aborts the operation immediately and applies the reset values above.

## Timing
- `up` at cycle t:
  - `channel`/`K` are updated and `mute`=`busy`=1 at t+1.
  - `mute`=`busy`=0 at t+1+SETTLE.
- Scan dwell per non-matching channel is 1 (STEP) + SETTLE + AVG + 1 (EVAL) cycles.
- `scan_done` is asserted in the cycle after EVAL, coincident with the IDLE/SETTLE transition.
- `mute` is 1 throughout a scan until `scan_done`.
- After reset release, `mute` deasserts after SETTLE cycles.

## Configuration
- `TUNER_CTRL_SCAN_EN` defined: scan logic (STEP, MEASURE, EVAL, accumulator, start-channel register) is present as described.
- Not defined:
  - The `scan` input is ignored.
  - `scan_done` and `scan_found` are tied to 0.
  - The `mag` and `threshold` inputs are unused.
  - The FSM reduces to IDLE/SETTLE. Manual tuning is unchanged.

## Test plan
Bench parameters: N_CH=4, K_BASE=1000, K_STEP=10, SETTLE=4, AVG=4.
- Reset, then release → `K`=1000, `channel`=0, `mute`=1 for 4 cycles, then `mute`=0, `busy`=0.
- `up` ×3, each after `busy` falls → `K`=1010, 1020, 1030; a 4th `up` → wrap to `K`=1000, `channel`=0; then `down` → `K`=1030, `channel`=3.
- `up` and `down` in the same cycle → no change. `up` while `busy` → dropped; `K` advances only once.
- Scan from channel 0, `threshold`=100, `mag`=200 only while `channel`=2, else 50 → stops at `K`=1020, `scan_found`=1, one `scan_done` pulse, `mute` falls the same cycle.
- Scan with `mag`=99 constant, `threshold`=100 → full lap, returns to `channel`=0, `scan_found`=0, `scan_done` pulse, `mute` clears 4 cycles later.
- Reset asserted mid-MEASURE → outputs return to reset values asynchronously. Without `TUNER_CTRL_SCAN_EN`, a `scan` pulse leaves `busy`=0.
